// File: rtl/range_result_logger_if.sv
// rtl/range_result_logger_if.sv - tracker/reader-side signal bundle for range_result_logger
// master drives capture and readout controls; slave is the logger itself.
interface range_result_logger_if #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 8
);
  logic [DATA_W-1:0] range_in;
  logic              range_valid;
  logic              error_in;
  logic              clear;
  logic              pop;
  logic [DATA_W-1:0] out_data;
  logic              out_err;
  logic              out_valid;
  logic              fifo_full;
  logic              overflow;
  logic [DATA_W-1:0] peak_range;
  logic [CNT_W-1:0]  session_count;
  logic [CNT_W-1:0]  error_count;

  modport master (
    output range_in, range_valid, error_in, clear, pop,
    input  out_data, out_err, out_valid, fifo_full, overflow,
           peak_range, session_count, error_count
  );

  modport slave (
    input  range_in, range_valid, error_in, clear, pop,
    output out_data, out_err, out_valid, fifo_full, overflow,
           peak_range, session_count, error_count
  );
endinterface

// File: rtl/range_result_logger.sv
// rtl/range_result_logger.sv - per-session range capture into a show-ahead FIFO with running stats
// One capture per rising edge of range_valid; outputs come only from registered state.
module range_result_logger #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  range_result_logger_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic              mem_err_q  [DEPTH];

  logic [AW-1:0]     rd_q, rd_d;
  logic [AW-1:0]     wr_q, wr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              rv_q;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] peak_q, peak_d;
  logic [CNT_W-1:0]  session_q, session_d;
  logic [CNT_W-1:0]  errcnt_q, errcnt_d;

  logic cap;
  logic empty;
  logic full;
  logic push;
  logic pop_ok;

  assign cap   = bus.range_valid & ~rv_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  always_comb begin
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    peak_d     = peak_q;
    session_d  = session_q;
    errcnt_d   = errcnt_q;
    push       = 1'b0;
    pop_ok     = 1'b0;

    // clear wins over any coincident capture or pop
    if (bus.clear) begin
      rd_d       = '0;
      wr_d       = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      peak_d     = '0;
      session_d  = '0;
      errcnt_d   = '0;
    end else begin
      pop_ok = bus.pop & ~empty;
      if (cap) begin
        // a full FIFO still accepts the push when the head leaves on the same edge
        if (!full || pop_ok) begin
          push = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
        if (session_q != '1) session_d = session_q + CNT_W'(1);
        if (bus.error_in && (errcnt_q != '1)) errcnt_d = errcnt_q + CNT_W'(1);
        if (bus.range_in > peak_q) peak_d = bus.range_in;
      end
      if (push)   wr_d = wr_q + AW'(1);
      if (pop_ok) rd_d = rd_q + AW'(1);
      case ({push, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      rv_q       <= 1'b0;
      overflow_q <= 1'b0;
      peak_q     <= '0;
      session_q  <= '0;
      errcnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_err_q[i]  <= 1'b0;
      end
    end else begin
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      rv_q       <= bus.range_valid;
      overflow_q <= overflow_d;
      peak_q     <= peak_d;
      session_q  <= session_d;
      errcnt_q   <= errcnt_d;
      if (push) begin
        mem_data_q[wr_q] <= bus.range_in;
        mem_err_q[wr_q]  <= bus.error_in;
      end
    end
  end

  assign bus.out_data      = empty ? '0 : mem_data_q[rd_q];
  assign bus.out_err       = empty ? 1'b0 : mem_err_q[rd_q];
  assign bus.out_valid     = ~empty;
  assign bus.fifo_full     = full;
  assign bus.overflow      = overflow_q;
  assign bus.peak_range    = peak_q;
  assign bus.session_count = session_q;
  assign bus.error_count   = errcnt_q;
endmodule

// File: tb/tb_range_result_logger.sv
// tb/tb_range_result_logger.sv - directed self-checking bench for range_result_logger
module tb_range_result_logger;
  localparam int DATA_W = 10;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  range_result_logger_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  range_result_logger #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic capture(input logic [DATA_W-1:0] v, input logic e);
    bus.range_valid = 1'b1;
    bus.range_in    = v;
    bus.error_in    = e;
    step();
    bus.range_valid = 1'b0;
    bus.error_in    = 1'b0;
    step();
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] exp);
    check(tag, 32'(bus.out_data), exp);
    bus.pop = 1'b1;
    step();
    bus.pop = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.range_in    = '0;
    bus.range_valid = 1'b0;
    bus.error_in    = 1'b0;
    bus.clear       = 1'b0;
    bus.pop         = 1'b0;
    step();
    step();
    check("rst_valid",   32'(bus.out_valid), 0);
    check("rst_data",    32'(bus.out_data), 0);
    check("rst_full",    32'(bus.fifo_full), 0);
    check("rst_ovf",     32'(bus.overflow), 0);
    check("rst_peak",    32'(bus.peak_range), 0);
    check("rst_session", 32'(bus.session_count), 0);
    check("rst_errcnt",  32'(bus.error_count), 0);
    reset = 1'b0;
    step();

    // single capture, one-cycle latency
    bus.range_valid = 1'b1;
    bus.range_in    = 10'd300;
    step();
    bus.range_valid = 1'b0;
    check("t1_valid",   32'(bus.out_valid), 1);
    check("t1_data",    32'(bus.out_data), 300);
    check("t1_err",     32'(bus.out_err), 0);
    check("t1_peak",    32'(bus.peak_range), 300);
    check("t1_session", 32'(bus.session_count), 1);
    check("t1_errcnt",  32'(bus.error_count), 0);
    step();

    // long pulse captures once; second pulse captures again
    pulse_clear();
    check("clr_valid", 32'(bus.out_valid), 0);
    check("clr_peak",  32'(bus.peak_range), 0);
    bus.range_valid = 1'b1;
    bus.range_in    = 10'd50;
    for (int i = 0; i < 5; i++) step();
    check("t2_session1", 32'(bus.session_count), 1);
    check("t2_head1",    32'(bus.out_data), 50);
    bus.range_valid = 1'b0;
    step();
    bus.range_valid = 1'b1;
    bus.range_in    = 10'd70;
    step();
    bus.range_valid = 1'b0;
    check("t2_session2", 32'(bus.session_count), 2);
    check("t2_peak",     32'(bus.peak_range), 70);
    step();
    pop_expect("t2_pop50", 50);
    pop_expect("t2_pop70", 70);
    check("t2_empty", 32'(bus.out_valid), 0);

    // overflow with five captures into four entries
    pulse_clear();
    capture(10'd10, 1'b0);
    capture(10'd20, 1'b1);
    capture(10'd30, 1'b0);
    capture(10'd40, 1'b0);
    capture(10'd50, 1'b0);
    check("t3_full",    32'(bus.fifo_full), 1);
    check("t3_ovf",     32'(bus.overflow), 1);
    check("t3_session", 32'(bus.session_count), 5);
    check("t3_peak",    32'(bus.peak_range), 50);
    check("t3_errcnt",  32'(bus.error_count), 1);
    pop_expect("t3_pop10", 10);
    check("t3_err20", 32'(bus.out_err), 1);
    pop_expect("t3_pop20", 20);
    pop_expect("t3_pop30", 30);
    pop_expect("t3_pop40", 40);
    check("t3_empty_valid", 32'(bus.out_valid), 0);
    check("t3_empty_data",  32'(bus.out_data), 0);
    check("t3_empty_err",   32'(bus.out_err), 0);
    bus.pop = 1'b1;
    step();
    check("t3_underflow", 32'(bus.out_valid), 0);
    // push and pop together while empty: push lands
    bus.range_valid = 1'b1;
    bus.range_in    = 10'd77;
    step();
    bus.range_valid = 1'b0;
    bus.pop         = 1'b0;
    check("t3_emptypp_valid", 32'(bus.out_valid), 1);
    check("t3_emptypp_data",  32'(bus.out_data), 77);
    step();

    // full plus capture plus pop in one cycle
    pulse_clear();
    capture(10'd1, 1'b0);
    capture(10'd2, 1'b0);
    capture(10'd3, 1'b0);
    capture(10'd4, 1'b0);
    bus.range_valid = 1'b1;
    bus.range_in    = 10'd5;
    bus.pop         = 1'b1;
    step();
    bus.range_valid = 1'b0;
    bus.pop         = 1'b0;
    check("t4_ovf",  32'(bus.overflow), 0);
    check("t4_full", 32'(bus.fifo_full), 1);
    check("t4_head", 32'(bus.out_data), 2);
    step();
    pop_expect("t4_pop2", 2);
    pop_expect("t4_pop3", 3);
    pop_expect("t4_pop4", 4);
    pop_expect("t4_pop5", 5);
    check("t4_empty", 32'(bus.out_valid), 0);

    // counter saturation, then clear
    pulse_clear();
    for (int i = 0; i < 260; i++) capture(10'(i), 1'b1);
    check("t5_session", 32'(bus.session_count), 255);
    check("t5_errcnt",  32'(bus.error_count), 255);
    check("t5_peak",    32'(bus.peak_range), 259);
    check("t5_ovf",     32'(bus.overflow), 1);
    pulse_clear();
    check("t5_clr_session", 32'(bus.session_count), 0);
    check("t5_clr_errcnt",  32'(bus.error_count), 0);
    check("t5_clr_ovf",     32'(bus.overflow), 0);
    check("t5_clr_valid",   32'(bus.out_valid), 0);
    check("t5_clr_full",    32'(bus.fifo_full), 0);
    check("t5_clr_peak",    32'(bus.peak_range), 0);

    // clear with range_valid held high does not recapture
    bus.range_valid = 1'b1;
    bus.range_in    = 10'd33;
    step();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    step();
    check("t5_hold_session", 32'(bus.session_count), 0);
    check("t5_hold_valid",   32'(bus.out_valid), 0);
    bus.range_valid = 1'b0;
    step();

    // asynchronous reset mid-stream
    capture(10'd11, 1'b0);
    capture(10'd12, 1'b0);
    capture(10'd13, 1'b1);
    check("t6_pre_head", 32'(bus.out_data), 11);
    #1;
    reset = 1'b1;
    #1;
    check("t6_async_valid",   32'(bus.out_valid), 0);
    check("t6_async_data",    32'(bus.out_data), 0);
    check("t6_async_session", 32'(bus.session_count), 0);
    check("t6_async_peak",    32'(bus.peak_range), 0);
    bus.range_valid = 1'b1;
    bus.range_in    = 10'd99;
    step();
    reset = 1'b0;
    step();
    check("t6_relcap_valid",   32'(bus.out_valid), 1);
    check("t6_relcap_data",    32'(bus.out_data), 99);
    check("t6_relcap_session", 32'(bus.session_count), 1);
    step();
    check("t6_relcap_once", 32'(bus.session_count), 1);
    bus.range_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/range_result_logger.md
Name: range_result_logger

Overview:
- Downstream consumer of the min/max range tracker. Captures one range result per measurement session on the rising edge of the tracker's finish-qualified valid, together with the tracker's error flag.
- Keeps results in a small show-ahead FIFO for a slow reader, plus running statistics: peak range, session count and error count.
- Sits between the range tracker and the chip's output mux or readout logic.

Parameters:
- DATA_W, 10, width of range result.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- CNT_W, 8, width of session and error counters.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- range_in  input  DATA_W  range value from tracker; valid only while range_valid=1.
- range_valid  input  1  level; high while tracker's finish is asserted; may stay high many cycles.
- error_in  input  1  tracker debug/error flag, sampled only at capture.
- clear  input  1  synchronous clear of FIFO, statistics and overflow.
- pop  input  1  reader consumes FIFO head this cycle.
- out_data  output  DATA_W  FIFO head range (show-ahead); 0 when empty.
- out_err  output  1  error flag stored with head entry; 0 when empty.
- out_valid  output  1  FIFO non-empty.
- fifo_full  output  1  FIFO holds DEPTH entries.
- overflow  output  1  sticky; a capture was dropped because the FIFO was full.
- peak_range  output  DATA_W  largest range captured since reset/clear.
- session_count  output  CNT_W  captures seen, including dropped ones; saturating.
- error_count  output  CNT_W  captures with error_in=1; saturating.

Behaviour:
- Reset (async): FIFO empty (rd/wr pointers 0, count 0); out_data=0, out_err=0, out_valid=0, fifo_full=0, overflow=0, peak_range=0, session_count=0, error_count=0, rv_q=0.
- Edge detect:
  - rv_q is a register holding the previous cycle's range_valid.
  - cap = range_valid & ~rv_q. Exactly one capture per high pulse, whatever its length.
  - rv_q resets to 0. If range_valid is high on the first edge after reset, that edge captures.
- Capture (cap=1, clear=0), all on the same clock edge:
  - push {error_in, range_in} if not full;
  - session_count += 1, saturating at 2^CNT_W−1;
  - error_count += 1 if error_in, saturating;
  - peak_range = max(peak_range, range_in), unsigned compare.
- Pop: effective only when out_valid=1; advances the read pointer. Pop while empty is ignored, with no pointer or count change.
- Simultaneous push and pop:
  - non-empty: both occur, count unchanged.
  - empty: the push lands and pop is ignored, so out_valid rises next cycle.
  - full: both occur, no overflow.
- Push while full without pop: entry dropped, overflow←1 (sticky). Statistics still update.
- Pointers: wrap modulo DEPTH. fifo_full and out_valid derive from a registered occupancy count (0..DEPTH).
- Latency: a captured value appears on out_data/out_valid on the cycle after the capture edge when the FIFO was empty.
- clear=1:
  - Next edge: FIFO empty, statistics and overflow zeroed.
  - clear has priority over a coincident capture or pop; those are discarded.
  - rv_q still updates, so a range_valid held high through clear does not recapture.
- Mid-operation reset: all state lost immediately, including FIFO contents; no partial state.
- All outputs are registered or derived from registered state only; no combinational input→output paths.

Test Plan:
- Reset, then range_valid high 1 cycle, range_in=300, error_in=0 -> next cycle out_valid=1, out_data=300, out_err=0, peak_range=300, session_count=1, error_count=0.
- range_valid held high 5 cycles with range_in=50 -> exactly one entry, session_count=1. Drop for 1 cycle, raise with 70 -> second entry, count=2, peak=70.
- Five captures (10, 20, 30, 40, 50) with no pops, DEPTH=4 -> fifo_full=1, overflow=1, session_count=5, peak=50. Pops return 10, 20, 30, 40, then out_valid=0 and out_data=0.
- FIFO full plus capture with pop in the same cycle -> no overflow, head advances, new value enqueued at tail, fifo_full stays 1.
- 260 captures with error_in=1 -> session_count=255 and error_count=255 (saturated). clear pulse -> all zero next cycle, overflow=0.
- Assert reset async mid-stream with 3 entries queued -> outputs zero without a clock edge. range_valid held high across reset release -> capture on first clock.
